// File: rtl/kfpga_config_pkg.sv
// Shared configuration-loader types and default chain geometry for the kFPGA IO ring.
package kfpga_config_pkg;

    localparam int TILE_CONFIG_WIDTH    = 36;
    localparam int NUM_IO_TILES         = 8;
    localparam int DEFAULT_CHAIN_LENGTH = NUM_IO_TILES * TILE_CONFIG_WIDTH;
    localparam int DEFAULT_WORD_WIDTH   = 32;
    localparam int DEFAULT_CLEAR_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_FETCH  = 3'd2,
        ST_SHIFT  = 3'd3,
        ST_FINISH = 3'd4
    } loader_state_t;

endpackage

// File: rtl/config_word_serializer.sv
// Captures one host word and presents it LSB-first, tracking how many of its bits remain to shift.
module config_word_serializer #(
    parameter int WORD_WIDTH = 32,
    parameter int BIT_CNT_W  = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [WORD_WIDTH-1:0] i_word,
    input  logic [BIT_CNT_W-1:0]  i_bits,
    output logic                  o_bit,
    output logic                  o_last
);

    logic [WORD_WIDTH-1:0] r_shift_reg;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift_reg <= '0;
            r_bit_cnt   <= '0;
        end else if (i_load) begin
            r_shift_reg <= i_word;
            r_bit_cnt   <= i_bits;
        end else if (i_shift) begin
            r_shift_reg <= r_shift_reg >> 1;
            r_bit_cnt   <= r_bit_cnt - 1'b1;
        end
    end

    assign o_bit  = r_shift_reg[0];
    // Asserted while the final used bit of the current word is on the output.
    assign o_last = (r_bit_cnt == BIT_CNT_W'(1));

endmodule

// File: rtl/config_chain_loader.sv
// Streams host bitstream words serially into the IO-tile configuration chain.
// Optional chain clear pulse before loading is compiled in with CONFIG_LOADER_CLEAR_EN.
module config_chain_loader
    import kfpga_config_pkg::*;
#(
    parameter int CHAIN_LENGTH = DEFAULT_CHAIN_LENGTH,
    parameter int WORD_WIDTH   = DEFAULT_WORD_WIDTH,
    parameter int CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_in,
    output logic                  config_enable,
    output logic                  config_nreset,
    output logic                  fabric_enable,
    output logic                  busy,
    output logic                  done,
    output loader_state_t         dbg_state
);

    localparam int REM_W = $clog2(CHAIN_LENGTH + 1);
    localparam int BIT_W = $clog2(WORD_WIDTH + 1);

    // Handshake: a word transfers on any cycle where word_valid and word_ready are both high;
    // word_ready is only ever high in FETCH and does not depend on word_valid.
    loader_state_t      r_state;
    loader_state_t      w_next_state;
    logic [REM_W-1:0]   r_remaining;
    logic               r_fabric_enable;
    logic [BIT_W-1:0]   w_word_bits;
    logic               w_accept;
    logic               w_shift;
    logic               w_bit;
    logic               w_last;

`ifdef CONFIG_LOADER_CLEAR_EN
    localparam int CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
    logic [CLR_W-1:0]   r_clear_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_clear_cnt <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_clear_cnt <= CLR_W'(CLEAR_CYCLES - 1);
        end else if (r_state == ST_CLEAR && r_clear_cnt != '0) begin
            r_clear_cnt <= r_clear_cnt - 1'b1;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_remaining     <= '0;
            r_fabric_enable <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_remaining     <= REM_W'(CHAIN_LENGTH);
                r_fabric_enable <= 1'b0;
            end else if (w_shift) begin
                r_remaining <= r_remaining - 1'b1;
            end
            if (r_state == ST_FINISH) begin
                r_fabric_enable <= 1'b1;
            end
        end
    end

    // The final word may be partial; its unused upper bits are never shifted.
    always_comb begin
        w_word_bits = BIT_W'(WORD_WIDTH);
        if (32'(r_remaining) < WORD_WIDTH) begin
            w_word_bits = BIT_W'(r_remaining);
        end
    end

    always_comb begin
        w_next_state  = r_state;
        word_ready    = 1'b0;
        config_enable = 1'b0;
        config_in     = 1'b0;
        config_nreset = 1'b1;
        busy          = 1'b1;
        done          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
`ifdef CONFIG_LOADER_CLEAR_EN
                    w_next_state = ST_CLEAR;
`else
                    w_next_state = ST_FETCH;
`endif
                end
            end
`ifdef CONFIG_LOADER_CLEAR_EN
            ST_CLEAR: begin
                config_nreset = 1'b0;
                if (r_clear_cnt == '0) begin
                    w_next_state = ST_FETCH;
                end
            end
`endif
            ST_FETCH: begin
                word_ready = 1'b1;
                if (word_valid) begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                config_enable = 1'b1;
                config_in     = w_bit;
                if (w_last) begin
                    w_next_state = (r_remaining == REM_W'(1)) ? ST_FINISH : ST_FETCH;
                end
            end
            ST_FINISH: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_accept      = (r_state == ST_FETCH) && word_valid;
    assign w_shift       = (r_state == ST_SHIFT);
    assign fabric_enable = r_fabric_enable;
    assign dbg_state     = r_state;

    config_word_serializer #(
        .WORD_WIDTH (WORD_WIDTH),
        .BIT_CNT_W  (BIT_W)
    ) u_serializer (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_accept),
        .i_shift (w_shift),
        .i_word  (word_data),
        .i_bits  (w_word_bits),
        .o_bit   (w_bit),
        .o_last  (w_last)
    );

endmodule

// File: tb/tb_config_chain_loader.sv
// Self-checking bench for config_chain_loader with a 36-bit chain fed by 8-bit words.
module tb_config_chain_loader;
    import kfpga_config_pkg::*;

    localparam int CL      = 36;
    localparam int WW      = 8;
    localparam int CC      = 4;
    localparam int N_WORDS = (CL + WW - 1) / WW;
`ifdef CONFIG_LOADER_CLEAR_EN
    localparam int CLEAR_LAT = CC;
`else
    localparam int CLEAR_LAT = 0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [WW-1:0] word_data;
    logic          word_valid;
    logic          word_ready;
    logic          config_in;
    logic          config_enable;
    logic          config_nreset;
    logic          fabric_enable;
    logic          busy;
    logic          done;
    loader_state_t dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    logic [0:0] exp_q[$];
    logic [WW-1:0] words[N_WORDS];
    int cyc = 0;
    int start_cyc;
    int done_cyc;
    int accept_cnt;
    int done_cnt;
    int shifted_cnt;
    int nreset_low_cnt;

    config_chain_loader #(
        .CHAIN_LENGTH (CL),
        .WORD_WIDTH   (WW),
        .CLEAR_CYCLES (CC)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .word_data     (word_data),
        .word_valid    (word_valid),
        .word_ready    (word_ready),
        .config_in     (config_in),
        .config_enable (config_enable),
        .config_nreset (config_nreset),
        .fabric_enable (fabric_enable),
        .busy          (busy),
        .done          (done),
        .dbg_state     (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: the chain sees the words' bits LSB-first, truncated to CL bits in total.
    function automatic void build_expected();
        int rem;
        rem = CL;
        exp_q.delete();
        for (int i = 0; i < N_WORDS; i++) begin
            int n;
            n = (rem < WW) ? rem : WW;
            for (int b = 0; b < n; b++) exp_q.push_back(words[i][b]);
            rem -= n;
        end
    endfunction

    // Scoreboard monitor on the falling edge.
    always @(negedge clock) begin
        cyc++;
        if (reset !== 1'b1) begin
            if (config_enable) begin
                shifted_cnt++;
                if (exp_q.size() == 0) check("extra_bit", config_enable, 0);
                else check("bit", config_in, exp_q.pop_front());
            end
            if (word_ready) check("en_in_fetch", config_enable, 0);
            if (word_valid && word_ready) accept_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (!config_nreset) begin
                nreset_low_cnt++;
                check("ready_in_clear", word_ready, 0);
            end
        end
    end

    task automatic feed_word(input logic [WW-1:0] w);
        int budget;
        budget = 0;
        word_data  = w;
        word_valid = 1'b1;
        @(negedge clock);
        while (!word_ready && budget < 200) begin
            @(negedge clock);
            budget++;
        end
        if (!word_ready) check("ready_timeout", word_ready, 1);
        @(posedge clock); #1;
    endtask

    task automatic begin_load();
        build_expected();
        accept_cnt     = 0;
        done_cnt       = 0;
        shifted_cnt    = 0;
        nreset_low_cnt = 0;
        done_cyc       = -1;
        @(posedge clock); #1;
        start     = 1'b1;
        start_cyc = cyc + 1;
        @(posedge clock); #1;
        start = 1'b0;
        check("fabric_drop", fabric_enable, 0);
    endtask

    task automatic do_load(input int gap_idx, input int gap_len, input bit spurious, input bit check_lat);
        int budget;
        begin_load();
        for (int i = 0; i < N_WORDS; i++) begin
            feed_word(words[i]);
            if (i == gap_idx) begin
                word_valid = 1'b0;
                for (int g = 0; g < gap_len; g++) begin
                    start = spurious;
                    @(posedge clock); #1;
                    start = 1'b0;
                end
            end
        end
        word_valid = 1'b0;
        budget = 0;
        while (done_cnt == 0 && budget < 200) begin
            @(negedge clock); #1;
            budget++;
        end
        repeat (3) @(negedge clock);
        #1;
        check("done_cnt", done_cnt, 1);
        check("accept_cnt", accept_cnt, N_WORDS);
        check("bits_shifted", shifted_cnt, CL);
        check("exp_left", exp_q.size(), 0);
        check("fabric_en", fabric_enable, 1);
        check("busy_after", busy, 0);
        check("nreset_low", nreset_low_cnt, CLEAR_LAT);
        if (check_lat) check("latency", done_cyc - start_cyc, N_WORDS + CL + 1 + CLEAR_LAT);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, word_ready, 0);
        check({tag, "_cin"}, config_in, 0);
        check({tag, "_cen"}, config_enable, 0);
        check({tag, "_nrst"}, config_nreset, 1);
        check({tag, "_fab"}, fabric_enable, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic randomize_words();
        for (int i = 0; i < N_WORDS; i++) words[i] = WW'($urandom_range(0, 255));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        logic [WW-1:0] extra;
        int acc_snapshot;
        reset      = 1'b1;
        start      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("rst");
        @(posedge clock); #1;
        reset = 1'b0;

        // Directed stream, valid always high.
        words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h0B;
        do_load(-1, 0, 1'b0, 1'b1);

        // Same stream with a 10-cycle valid gap between words 2 and 3, starts pulsed in the gap.
        do_load(1, 10, 1'b1, 1'b0);

        // A sixth word offered after completion must not be taken.
        extra        = WW'($urandom_range(0, 255));
        acc_snapshot = accept_cnt;
        word_data    = extra;
        word_valid   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            check("ready_after_done", word_ready, 0);
        end
        #1;
        check("no_consume", accept_cnt, acc_snapshot);
        word_valid = 1'b0;

        // Reset in the middle of a load, after 20 shifted bits.
        randomize_words();
        begin_load();
        for (int i = 0; i < 3; i++) feed_word(words[i]);
        word_valid = 1'b0;
        budget = 0;
        while (shifted_cnt < 20 && budget < 100) begin
            @(negedge clock); #1;
            budget++;
        end
        check("bits_before_rst", shifted_cnt, 20);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check("fabric_after_rst", fabric_enable, 0);

        // Fresh full load after the abandoned one, then randomized loads.
        randomize_words();
        do_load(-1, 0, 1'b0, 1'b1);
        for (int r = 0; r < 6; r++) begin
            int glen;
            randomize_words();
            glen = $urandom_range(0, 12);
            do_load($urandom_range(0, N_WORDS - 1), glen, 1'($urandom_range(0, 1)), glen == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
